// File: rtl/mtimer_responder.sv
// Memory-mapped machine timer responder on the core data-memory port.
// 64-bit mtime with prescaler, 64-bit mtimecmp, ctrl, registered timer_irq.
module mtimer_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  byte_en,
    output logic        hit,
    output logic [31:0] read_data,
    output logic        timer_irq
);

    logic [63:0]           r_mtime;
    logic [63:0]           r_cmp;
    logic [1:0]            r_ctrl;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [31:0]           r_hi_shadow;
    logic                  r_irq;

    logic [2:0]  w_off;
    logic [31:0] w_mask;
    logic        w_we;
    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_wr_clo;
    logic        w_wr_chi;
    logic        w_wr_ctl;
    logic        w_wr_pre;
    logic        w_tick;
    logic        w_rd_lo;
    logic [31:0] w_ctrl_ext;
    logic [31:0] w_pre_ext;
    logic [31:0] w_ctrl_new;
    logic [31:0] w_pre_new;
    logic [31:0] w_rd;

    function automatic logic [31:0] merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [31:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign hit    = (address[31:5] == BASE_ADDR[31:5]);
    assign w_off  = address[4:2];
    assign w_mask = {{8{byte_en[3]}}, {8{byte_en[2]}},
                     {8{byte_en[1]}}, {8{byte_en[0]}}};

    // An all-zero byte_en is treated exactly like no write at all.
    assign w_we     = mem_write & hit & (|byte_en);
    assign w_wr_lo  = w_we & (w_off == 3'd0);
    assign w_wr_hi  = w_we & (w_off == 3'd1);
    assign w_wr_clo = w_we & (w_off == 3'd2);
    assign w_wr_chi = w_we & (w_off == 3'd3);
    assign w_wr_ctl = w_we & (w_off == 3'd4);
    assign w_wr_pre = w_we & (w_off == 3'd5);
    assign w_rd_lo  = mem_read & hit & (w_off == 3'd0);

    assign w_tick     = r_ctrl[0] & (r_pcnt == r_prescale);
    assign w_ctrl_ext = {30'd0, r_ctrl};
    assign w_pre_ext  = 32'(r_prescale);
    assign w_ctrl_new = merge(w_ctrl_ext, write_data, w_mask);
    assign w_pre_new  = merge(w_pre_ext, write_data, w_mask);

    always_comb begin
        w_rd = 32'd0;
        if (mem_read & hit) begin
            case (w_off)
                3'd0:    w_rd = r_mtime[31:0];
                3'd1:    w_rd = r_hi_shadow;
                3'd2:    w_rd = r_cmp[31:0];
                3'd3:    w_rd = r_cmp[63:32];
                3'd4:    w_rd = w_ctrl_ext;
                3'd5:    w_rd = w_pre_ext;
                default: w_rd = 32'd0;
            endcase
        end
    end

    assign read_data = w_rd;
    assign timer_irq = r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime     <= 64'd0;
            r_cmp       <= '1;
            r_ctrl      <= 2'd0;
            r_prescale  <= '0;
            r_pcnt      <= '0;
            r_hi_shadow <= 32'd0;
            r_irq       <= 1'b0;
        end else begin
            if (w_rd_lo)
                r_hi_shadow <= r_mtime[63:32];

            r_irq <= r_ctrl[1] & (r_mtime >= r_cmp);

            // A software write to either half suppresses that cycle's tick.
            if (w_wr_lo)
                r_mtime[31:0] <= merge(r_mtime[31:0], write_data, w_mask);
            else if (w_wr_hi)
                r_mtime[63:32] <= merge(r_mtime[63:32], write_data, w_mask);
            else if (w_tick)
                r_mtime <= r_mtime + 64'd1;

            if (w_wr_clo)
                r_cmp[31:0] <= merge(r_cmp[31:0], write_data, w_mask);
            if (w_wr_chi)
                r_cmp[63:32] <= merge(r_cmp[63:32], write_data, w_mask);

            if (w_wr_ctl)
                r_ctrl <= w_ctrl_new[1:0];

            if (w_wr_pre) begin
                r_prescale <= w_pre_new[PRESCALE_W-1:0];
                r_pcnt     <= '0;
            end else if (r_ctrl[0]) begin
                r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mtimer_responder.sv
// Bench for mtimer_responder: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_mtimer_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_en;
    logic        hit;
    logic [31:0] read_data;
    logic        timer_irq;

    mtimer_responder #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .byte_en(byte_en),
        .hit(hit), .read_data(read_data), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [1:0]  m_ctrl;
    logic [15:0] m_pre;
    int          m_pcnt;
    logic [31:0] m_shadow;
    logic        m_irq;

    logic        t_we;
    logic [2:0]  t_off;
    logic        t_tick;
    logic [31:0] t_w;

    logic        lit_en = 1'b0;
    logic        lit_kind;
    logic [31:0] lit_val;
    logic        lit_hit;
    string       lit_name;

    function automatic logic in_win(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd();
        if (!(mem_read && in_win(address))) return 32'd0;
        case (address[4:2])
            3'd0: return m_mtime[31:0];
            3'd1: return m_shadow;
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
            3'd4: return {30'd0, m_ctrl};
            3'd5: return {16'd0, m_pre};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mtime  <= 64'd0;
            m_cmp    <= {64{1'b1}};
            m_ctrl   <= 2'd0;
            m_pre    <= 16'd0;
            m_pcnt   <= 0;
            m_shadow <= 32'd0;
            m_irq    <= 1'b0;
        end else begin
            t_we   = mem_write && in_win(address) && (byte_en != 4'd0);
            t_off  = address[4:2];
            t_tick = m_ctrl[0] && (m_pcnt == int'(m_pre));
            m_irq <= m_ctrl[1] && (m_mtime >= m_cmp);
            if (mem_read && in_win(address) && t_off == 3'd0)
                m_shadow <= m_mtime[63:32];
            if (t_we && t_off == 3'd0)
                m_mtime <= {m_mtime[63:32],
                            mrg(m_mtime[31:0], write_data, byte_en)};
            else if (t_we && t_off == 3'd1)
                m_mtime <= {mrg(m_mtime[63:32], write_data, byte_en),
                            m_mtime[31:0]};
            else if (t_tick)
                m_mtime <= m_mtime + 64'd1;
            if (t_we && t_off == 3'd2)
                m_cmp <= {m_cmp[63:32], mrg(m_cmp[31:0], write_data, byte_en)};
            if (t_we && t_off == 3'd3)
                m_cmp <= {mrg(m_cmp[63:32], write_data, byte_en), m_cmp[31:0]};
            if (t_we && t_off == 3'd4) begin
                t_w = mrg({30'd0, m_ctrl}, write_data, byte_en);
                m_ctrl <= t_w[1:0];
            end
            if (t_we && t_off == 3'd5) begin
                t_w = mrg({16'd0, m_pre}, write_data, byte_en);
                m_pre  <= t_w[15:0];
                m_pcnt <= 0;
            end else if (m_ctrl[0]) begin
                m_pcnt <= t_tick ? 0 : m_pcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] er;
        logic        eh;
        er = exp_rd();
        eh = in_win(address);
        vectors++;
        if (hit !== eh || read_data !== er || timer_irq !== m_irq) begin
            miscompares++;
            $display("FAIL model t=%0t hit=%b/%b read_data=%h/%h irq=%b/%b (got/want)",
                     $time, hit, eh, read_data, er, timer_irq, m_irq);
        end
        if (lit_en) begin
            vectors++;
            if (lit_kind == 1'b0) begin
                if (read_data !== lit_val || hit !== lit_hit) begin
                    miscompares++;
                    $display("FAIL %s: read_data=%h hit=%b, want %h hit=%b",
                             lit_name, read_data, hit, lit_val, lit_hit);
                end
            end else if (timer_irq !== lit_val[0]) begin
                miscompares++;
                $display("FAIL %s: timer_irq=%b, want %b",
                         lit_name, timer_irq, lit_val[0]);
            end
        end
    end

    task automatic idle();
        mem_read = 1'b0;
        mem_write = 1'b0;
        address = 32'd0;
        write_data = 32'd0;
        byte_en = 4'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d,
                      input logic [3:0] be);
        address = BASE + {27'd0, off};
        mem_write = 1'b1;
        write_data = d;
        byte_en = be;
        cyc();
        idle();
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] v,
                          input logic h, input string n);
        address = a;
        mem_read = 1'b1;
        lit_kind = 1'b0;
        lit_val = v;
        lit_hit = h;
        lit_name = n;
        lit_en = 1'b1;
        @(negedge clk);
        #1 lit_en = 1'b0;
        cyc();
        idle();
    endtask

    task automatic irq_chk(input logic v, input string n);
        lit_kind = 1'b1;
        lit_val = {31'd0, v};
        lit_name = n;
        lit_en = 1'b1;
        @(negedge clk);
        #1 lit_en = 1'b0;
        cyc();
    endtask

    initial begin
        logic [2:0] off;
        rst = 1'b1;
        idle();
        repeat (3) cyc();
        rst = 1'b0;

        rd_chk(BASE + 32'h8, 32'hFFFF_FFFF, 1'b1, "reset_cmp_lo");
        rd_chk(BASE + 32'h10, 32'h0, 1'b1, "reset_ctrl");

        wr(5'h10, 32'h1, 4'hF);
        repeat (10) cyc();
        rd_chk(BASE, 32'd10, 1'b1, "count10");
        rd_chk(BASE + 32'h40, 32'd0, 1'b0, "miss_0x40");

        do_reset();
        wr(5'h14, 32'd3, 4'hF);
        wr(5'h10, 32'h1, 4'hF);
        repeat (4) rd_chk(BASE, 32'd0, 1'b1, "pre3_wait0");
        rd_chk(BASE, 32'd1, 1'b1, "pre3_tick1");
        wr(5'h14, 32'd3, 4'hF);
        repeat (4) rd_chk(BASE, 32'd1, 1'b1, "pre_clr_wait");
        rd_chk(BASE, 32'd2, 1'b1, "pre_clr_tick2");

        do_reset();
        wr(5'h00, 32'hFFFF_FFFE, 4'hF);
        wr(5'h04, 32'h0, 4'hF);
        wr(5'h10, 32'h1, 4'hF);
        cyc();
        wr(5'h10, 32'h0, 4'hF);
        rd_chk(BASE, 32'd0, 1'b1, "carry_lo");
        rd_chk(BASE + 32'h4, 32'd1, 1'b1, "carry_hi_shadow");
        wr(5'h00, 32'hFFFF_FFFF, 4'hF);
        wr(5'h04, 32'hFFFF_FFFF, 4'hF);
        wr(5'h10, 32'h1, 4'hF);
        wr(5'h10, 32'h0, 4'hF);
        rd_chk(BASE, 32'd0, 1'b1, "wrap_lo");
        rd_chk(BASE + 32'h4, 32'd0, 1'b1, "wrap_hi");

        do_reset();
        wr(5'h0C, 32'h0, 4'hF);
        wr(5'h08, 32'd5, 4'hF);
        wr(5'h10, 32'h3, 4'hF);
        repeat (6) irq_chk(1'b0, "irq_before");
        irq_chk(1'b1, "irq_assert");
        wr(5'h08, 32'd100, 4'hF);
        irq_chk(1'b1, "irq_hold_1cyc");
        irq_chk(1'b0, "irq_drop");

        wr(5'h08, 32'd0, 4'hF);
        irq_chk(1'b0, "irq_relatch");
        irq_chk(1'b1, "irq_on_pre_rst");
        address = BASE;
        mem_write = 1'b1;
        write_data = 32'h55;
        byte_en = 4'hF;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        idle();
        irq_chk(1'b0, "rst_irq");
        rd_chk(BASE, 32'd0, 1'b1, "rst_mtime_lo");
        rd_chk(BASE + 32'hC, 32'hFFFF_FFFF, 1'b1, "rst_cmp_hi");
        rd_chk(BASE + 32'h10, 32'd0, 1'b1, "rst_ctrl");

        wr(5'h08, 32'h0000_AB00, 4'b0010);
        rd_chk(BASE + 32'h8, 32'hFFFF_ABFF, 1'b1, "byte_merge");
        wr(5'h08, 32'h1234_5678, 4'b0000);
        rd_chk(BASE + 32'h8, 32'hFFFF_ABFF, 1'b1, "byte_en_zero");

        wr(5'h10, 32'h1, 4'hF);
        repeat (3) cyc();
        wr(5'h00, 32'h1234, 4'hF);
        rd_chk(BASE, 32'h1234, 1'b1, "write_beats_tick");
        rd_chk(BASE + 32'h18, 32'd0, 1'b1, "rsvd_0x18");

        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            off = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 85)
                address = BASE + {27'd0, off, 2'($urandom)};
            else
                address = $urandom;
            mem_read = ($urandom_range(0, 1) == 1);
            mem_write = ($urandom_range(0, 9) < 3);
            byte_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (off)
                3'd0: write_data = ($urandom_range(0, 3) == 0) ?
                                   32'hFFFF_FFF0 : $urandom;
                3'd1: write_data = ($urandom_range(0, 3) == 0) ?
                                   32'hFFFF_FFFF : 32'($urandom_range(0, 2));
                3'd2: write_data = m_mtime[31:0] + 32'($urandom_range(0, 20));
                3'd3: write_data = ($urandom_range(0, 1) == 1) ?
                                   m_mtime[63:32] : $urandom;
                3'd5: write_data = 32'($urandom_range(0, 3));
                default: write_data = $urandom;
            endcase
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
